cmd_dispatch: RTL
=================

CMD_DISPATCH -- requirements
Module: cmd_dispatch

Interface
REQ-001 SHALL have parameter QOS_CLASS_NUM, default 4, number of QoS classes; class index QOS_CLASS_NUM-1 is highest priority.
REQ-002 SHALL have parameter PAYLD_BW, default 8, command payload width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 8, number of bypassing grants before a waiting class is promoted.
REQ-004 clk  input  1  sole clock; all logic on posedge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 class_pend  input  QOS_CLASS_NUM  bit i high = command buffer holds at least one class-i entry.
REQ-007 rd_en  output  QOS_CLASS_NUM  one-hot read strobe to command buffer, bit i = read class i.
REQ-008 payload_in  input  PAYLD_BW  buffer read data, valid the cycle after rd_en.
REQ-009 qos_in  input  $clog2(QOS_CLASS_NUM)  buffer read class, valid with payload_in.
REQ-010 m_valid  output  1  downstream command valid.
REQ-011 m_ready  input  1  downstream accept.
REQ-012 m_payload  output  PAYLD_BW  downstream command payload.
REQ-013 m_qos  output  $clog2(QOS_CLASS_NUM)  downstream command class.

Function
REQ-014 FSM states SHALL be IDLE, READ, CAPT; encoding implementation-defined.
REQ-015 IDLE->READ when |class_pend and output queue count + 0 in-flight < 2; else stay IDLE.
REQ-016 In READ, rd_en SHALL be one-hot for exactly one cycle on the granted class; READ->CAPT unconditionally.
REQ-017 In CAPT, payload_in/qos_in SHALL be written into the output queue; CAPT->IDLE unconditionally; rd_en is 0 in IDLE and CAPT.
REQ-018 Consequently at most one read per 3 cycles, preventing re-read of a class before class_pend reflects the prior read.
REQ-019 Grant SHALL be computed in IDLE from class_pend sampled that cycle and held registered through READ.
REQ-020 Default arbitration SHALL be strict priority: highest pending class index wins.
REQ-021 Output queue SHALL be a 2-entry FIFO; m_payload/m_qos come from head; m_valid = count != 0.
REQ-022 Pop occurs on m_valid && m_ready; push in CAPT; simultaneous push and pop SHALL keep count unchanged and preserve order.
REQ-023 Queue SHALL never overflow: REQ-015 guarantees a free slot at CAPT; m_payload/m_qos SHALL hold stable while m_valid && !m_ready.
REQ-024 Latency: class_pend rising in IDLE with empty queue -> rd_en next cycle -> m_valid two cycles after rd_en.
REQ-025 class_pend dropping while in READ/CAPT SHALL NOT abort the transaction; data is still captured.

Reset
REQ-026 On clk edge with rst_n low: state=IDLE, rd_en=0, queue count=0, m_valid=0, m_payload=0, m_qos=0, starvation counters=0.
REQ-027 Reset asserted mid-READ or mid-CAPT SHALL discard the in-flight read; no capture after reset release.

Configuration
REQ-028 Macro CMD_DISPATCH_STARVE_EN SHALL, when defined, compile in per-class starvation counters of width $clog2(STARVE_LIMIT+1).
REQ-029 With macro: counter i increments, saturating at STARVE_LIMIT, each grant to another class while class_pend[i]=1; clears when class i granted or class_pend[i]=0.
REQ-030 With macro: any class with counter == STARVE_LIMIT SHALL win over strict priority; among several, highest index wins.
REQ-031 Without macro: no counters exist, pure strict priority per REQ-020.

Verification
REQ-032 class_pend=4'b0101, m_ready=1 -> rd_en=4'b0100 one cycle, then capture, m_valid with m_qos=2.
REQ-033 m_ready=0, class_pend=4'b1111 constantly -> exactly two reads issued, m_valid stays 1, no third rd_en until a pop.
REQ-034 Push and pop same cycle with count=1 -> count stays 1, order of payloads 0xA1 then 0xB2 preserved.
REQ-035 STARVE_EN, STARVE_LIMIT=2, class_pend=4'b1001 held -> grants 3,3,0 sequence; without macro class 0 never granted.
REQ-036 rst_n low during READ -> next cycles rd_en=0, m_valid=0, payload_in ignored.

Source files
------------

// File: rtl/cmd_dispatch_if.sv
// Command dispatcher bus: command-buffer read side plus downstream valid/ready stream.
// The master modport is the dispatcher; the slave modport is the buffer/consumer side.
interface cmd_dispatch_if #(
  parameter int QOS_CLASS_NUM = 4,
  parameter int PAYLD_BW      = 8
);
  localparam int QW = $clog2(QOS_CLASS_NUM);

  logic [QOS_CLASS_NUM-1:0] class_pend;
  logic [QOS_CLASS_NUM-1:0] rd_en;
  logic [PAYLD_BW-1:0]      payload_in;
  logic [QW-1:0]            qos_in;
  logic                     m_valid;
  logic                     m_ready;
  logic [PAYLD_BW-1:0]      m_payload;
  logic [QW-1:0]            m_qos;

  modport master (
    input  class_pend, payload_in, qos_in, m_ready,
    output rd_en, m_valid, m_payload, m_qos
  );

  modport slave (
    output class_pend, payload_in, qos_in, m_ready,
    input  rd_en, m_valid, m_payload, m_qos
  );
endinterface

// File: rtl/cmd_dispatch.sv
// QoS command dispatcher: strict-priority read of a class buffer into a 2-entry output FIFO.
// Define CMD_DISPATCH_STARVE_EN to add per-class starvation promotion.
module cmd_dispatch #(
  parameter int QOS_CLASS_NUM = 4,
  parameter int PAYLD_BW      = 8,
  parameter int STARVE_LIMIT  = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  cmd_dispatch_if.master bus
);
  localparam int QW = $clog2(QOS_CLASS_NUM);
  localparam logic [QOS_CLASS_NUM-1:0] ONE_HOT0 = QOS_CLASS_NUM'(1);

  if (QOS_CLASS_NUM < 2 || STARVE_LIMIT < 1) begin : g_bad_params
    $error("cmd_dispatch: QOS_CLASS_NUM must be >= 2 and STARVE_LIMIT >= 1");
  end

  typedef enum logic [1:0] {IDLE, READ, CAPT} state_t;

  state_t                   state_q, state_d;
  logic [QW-1:0]            grant_q, grant_d;
  logic                     grant_take;
  logic                     push;
  logic                     pop;
  logic [QOS_CLASS_NUM-1:0] rd_en_d;

  logic [PAYLD_BW-1:0]      pay_q [2];
  logic [QW-1:0]            qos_q [2];
  logic                     wr_ptr_q, rd_ptr_q;
  logic [1:0]               count_q;

`ifdef CMD_DISPATCH_STARVE_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);
  logic [CW-1:0] starve_q [QOS_CLASS_NUM];
`endif

  // Arbitration: highest pending index, overridden by the highest starved class
  always_comb begin
    grant_d = '0;
    for (int i = 0; i < QOS_CLASS_NUM; i++) begin
      if (bus.class_pend[i]) grant_d = QW'(i);
    end
`ifdef CMD_DISPATCH_STARVE_EN
    for (int i = 0; i < QOS_CLASS_NUM; i++) begin
      if (bus.class_pend[i] && starve_q[i] == LIMIT) grant_d = QW'(i);
    end
`endif
  end

  always_comb begin
    state_d    = state_q;
    rd_en_d    = '0;
    push       = 1'b0;
    grant_take = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|bus.class_pend && count_q < 2'd2) begin
          state_d    = READ;
          grant_take = 1'b1;
        end
      end
      READ: begin
        rd_en_d = ONE_HOT0 << grant_q;
        state_d = CAPT;
      end
      CAPT: begin
        push    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      if (grant_take) grant_q <= grant_d;
    end
  end

  // Output FIFO: the IDLE admission check guarantees a free slot whenever CAPT pushes
  assign pop = (count_q != 2'd0) && bus.m_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        pay_q[i] <= '0;
        qos_q[i] <= '0;
      end
    end else begin
      if (push) begin
        pay_q[wr_ptr_q] <= bus.payload_in;
        qos_q[wr_ptr_q] <= bus.qos_in;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef CMD_DISPATCH_STARVE_EN
  always_ff @(posedge clk) begin
    for (int i = 0; i < QOS_CLASS_NUM; i++) begin
      if (!rst_n || !bus.class_pend[i]) begin
        starve_q[i] <= '0;
      end else if (grant_take) begin
        if (grant_d == QW'(i))         starve_q[i] <= '0;
        else if (starve_q[i] != LIMIT) starve_q[i] <= starve_q[i] + CW'(1);
      end
    end
  end
`endif

  assign bus.rd_en     = rd_en_d;
  assign bus.m_valid   = (count_q != 2'd0);
  assign bus.m_payload = pay_q[rd_ptr_q];
  assign bus.m_qos     = qos_q[rd_ptr_q];
endmodule
